// File: rtl/mls_pkg.sv
// Shared definitions for the maximal-length sequence controller:
// FSM states, LFSR tap positions and the one-step LFSR transition.
package mls_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } mls_state_t;

  // Bit indices of s[] that feed the XOR for x^8+x^6+x^5+x^4+1.
  localparam int TAP0 = 0;
  localparam int TAP1 = 2;
  localparam int TAP2 = 3;
  localparam int TAP3 = 4;

  localparam int          MLS_PERIOD   = 255;
  localparam logic [7:0]  SEED_DEFAULT = 8'h01;
  localparam int          LEN_W_DEF    = 8;

  function automatic logic [7:0] mls_next(input logic [7:0] s);
    return {s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3], s[7:1]};
  endfunction

endpackage

// File: rtl/mls_lfsr8.sv
// 8-stage Fibonacci LFSR core; a load takes priority over an advance.
module mls_lfsr8
  import mls_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       adv,
  output logic [7:0] state
);

  logic [7:0] r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_VAL;
    end else if (load) begin
      r_state <= load_val;
    end else if (adv) begin
      r_state <= mls_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/mls_sequencer.sv
// Host-controlled MLS bit streamer: start/busy/done toward the host,
// valid/ready toward the consumer, plus wrap and zero-seed guarding.
//
// Handshake: a bit transfers on any rising edge where bit_valid && bit_ready;
// bit_valid, once high, stays high and bit_out stays stable until a transfer
// happens or the run is ended by stop.
module mls_sequencer
  import mls_pkg::*;
#(
  parameter logic [7:0] SEED_DEFAULT = mls_pkg::SEED_DEFAULT,
  parameter int         LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [LEN_W-1:0] len,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             seed_fixed,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             wrap,
  output logic [7:0]       state_out,
  output logic [1:0]       dbg_state
);

  mls_state_t       r_state;
  mls_state_t       w_next_state;
  logic [7:0]       r_seed;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remaining;
  logic             r_free;
  logic             r_seed_fixed;
  logic             r_aborted;
  logic             r_wrap;
  logic [7:0]       w_lfsr_state;
  logic [7:0]       w_lfsr_next;
  logic             w_xfer;
  logic             w_last;
  logic             w_accept;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_xfer      = (r_state == RUN) && bit_ready;
  assign w_last      = w_xfer && !r_free && (r_remaining == LEN_W'(1));
  assign w_lfsr_next = mls_next(w_lfsr_state);

  mls_lfsr8 #(
    .RESET_VAL (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (r_state == LOAD),
    .load_val (r_seed),
    .adv      (w_xfer),
    .state    (w_lfsr_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD;
      LOAD:    w_next_state = RUN;
      RUN: begin
        // The final transfer beats a simultaneous stop.
        if (w_last)    w_next_state = FINISH;
        else if (stop) w_next_state = IDLE;
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed       <= SEED_DEFAULT;
      r_len        <= '0;
      r_remaining  <= '0;
      r_free       <= 1'b0;
      r_seed_fixed <= 1'b0;
      r_aborted    <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_seed       <= (seed == 8'h00) ? SEED_DEFAULT : seed;
        r_seed_fixed <= (seed == 8'h00);
        r_len        <= len;
      end
      if (r_state == LOAD) begin
        r_remaining <= r_len;
        r_free      <= (r_len == '0);
      end else if (w_xfer && !r_free && (r_remaining != '0)) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_aborted <= (r_state == RUN) && stop && !w_last;
      r_wrap    <= w_xfer && (w_lfsr_next == r_seed);
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);
  assign bit_valid  = (r_state == RUN);
  assign bit_out    = w_lfsr_state[0];
  assign state_out  = w_lfsr_state;
  assign seed_fixed = r_seed_fixed;
  assign aborted    = r_aborted;
  assign wrap       = r_wrap;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mls_sequencer.sv
// Self-checking bench for mls_sequencer: reference sequence built from the
// feedback polynomial, expected-state queue as scoreboard, random ready/stop.
module tb_mls_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [7:0] len;
  logic       stop;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       seed_fixed;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       wrap;
  logic [7:0] state_out;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tbl [8];

  mls_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .len        (len),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .seed_fixed (seed_fixed),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .wrap       (wrap),
    .state_out  (state_out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1: stage k lives in s[8-k], so taps 8,6,5,4
  // are bits 0,2,3,4; new bit enters at stage 1 (s[7]).
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    logic fb;
    fb = s[8-8] ^ s[8-6] ^ s[8-5] ^ s[8-4];
    return {fb, s[7:1]};
  endfunction

  // Driver + checker for one run; entered and left at a negedge in IDLE.
  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // stop_at/start_at: transfer count at which stop / a stray start is driven (0 = never).
  task automatic run_case(input logic [7:0] sd, input int ln, input int rmode,
                          input int stop_at, input int start_at);
    logic [7:0] ld;
    logic [7:0] s;
    bit         fixed, exp_wrap, fin, ab, rdy, dup;
    bit         seen [256];
    int         xf, cyc, wraps;
    ld    = (sd == 8'h00) ? 8'h01 : sd;
    fixed = (sd == 8'h00);
    exp_q.delete();
    s = ld;
    for (int i = 0; i < ((ln == 0) ? 1000 : ln); i++) begin
      exp_q.push_back(s);
      s = ref_next(s);
    end
    foreach (seen[i]) seen[i] = 1'b0;
    start = 1'b1; seed = sd; len = ln[7:0]; stop = 1'b0; bit_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; seed = 8'($urandom); len = 8'($urandom);
    chk("load_busy", busy, 1);
    chk("load_valid", bit_valid, 0);
    chk("load_seed_fixed", seed_fixed, fixed);
    xf = 0; wraps = 0; exp_wrap = 1'b0; fin = 1'b0; ab = 1'b0; dup = 1'b0;
    for (cyc = 0; cyc < 3000 && !fin && !ab; cyc++) begin
      @(negedge clk);
      chk("run_valid", bit_valid, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_aborted", aborted, 0);
      chk("run_wrap", wrap, exp_wrap);
      chk("run_seed_fixed", seed_fixed, fixed);
      chk("run_state", state_out, exp_q[0]);
      chk("run_bit", bit_out, exp_q[0][0]);
      if (ld == 8'h01 && xf < 8) chk("walk_tbl", state_out, tbl[xf]);
      if (wrap) wraps++;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bit_ready = rdy;
      stop  = (stop_at != 0) && (xf == stop_at);
      start = (start_at != 0) && (xf == start_at);
      seed  = ~ld;
      len   = 8'd2;
      exp_wrap = 1'b0;
      if (rdy) begin
        if (xf < 255) begin
          if (seen[state_out]) dup = 1'b1;
          seen[state_out] = 1'b1;
        end
        void'(exp_q.pop_front());
        xf++;
        exp_wrap = (xf % 255 == 0);
      end
      if (ln != 0 && rdy && xf == ln) fin = 1'b1;
      else if (stop) ab = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; bit_ready = 1'b0;
    if (fin) begin
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 1);
      chk("fin_valid", bit_valid, 0);
      chk("fin_aborted", aborted, 0);
      chk("fin_wrap", wrap, exp_wrap);
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_wrap", wrap, 0);
    end else if (ab) begin
      chk("ab_aborted", aborted, 1);
      chk("ab_done", done, 0);
      chk("ab_valid", bit_valid, 0);
      chk("ab_busy", busy, 0);
      chk("ab_wrap", wrap, exp_wrap);
      if (exp_wrap) wraps++;
      @(negedge clk);
      chk("post_aborted", aborted, 0);
      chk("post_busy", busy, 0);
    end else begin
      chk("run_timeout", 1, 0);
    end
    if (ln == 0 && xf >= 255) begin
      chk("uniq255", dup, 0);
      chk("wrap_count", wraps, xf / 255);
    end
  endtask

  initial begin
    tbl = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2};
    reset = 1'b1; start = 1'b0; seed = 8'h00; len = 8'h00; stop = 1'b0; bit_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_seed_fixed", seed_fixed, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_state", state_out, 8'h01);
    reset = 1'b0;
    @(negedge clk);

    // stop in IDLE does nothing
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_aborted", aborted, 0);

    run_case(8'h01, 8, 0, 0, 0);
    run_case(8'h00, 3, 0, 0, 0);
    run_case(8'h5A, 0, 0, 600, 0);
    run_case(8'h01, 10, 1, 0, 0);
    run_case(8'h37, 0, 2, 20, 7);
    run_case(8'h33, 5, 0, 4, 0);
    for (int k = 0; k < 6; k++) begin
      int ln;
      ln = $urandom_range(1, 40);
      run_case(8'($urandom), ln, 2, $urandom_range(0, ln), $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a free run
    start = 1'b1; seed = 8'h01; len = 8'h00; bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bit_valid, 0);
    chk("mid_rst_state", state_out, 8'h01);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    @(negedge clk);
    reset = 1'b0; bit_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_after_aborted", aborted, 0);
    run_case(8'h01, 8, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
